// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: shared key codes, frame geometry and the row-priority helper.
//   KEY_0..KEY_F      : key codes {row_idx, col_idx}
//   KEYPAD_FRAME_COLS : columns per full scan frame
//   first_row()       : lowest active-low row in a 4-bit row sample
package keypad_scan_pkg;

   localparam logic [3:0] KEY_0 = 4'h0;
   localparam logic [3:0] KEY_1 = 4'h1;
   localparam logic [3:0] KEY_2 = 4'h2;
   localparam logic [3:0] KEY_3 = 4'h3;
   localparam logic [3:0] KEY_4 = 4'h4;
   localparam logic [3:0] KEY_5 = 4'h5;
   localparam logic [3:0] KEY_6 = 4'h6;
   localparam logic [3:0] KEY_7 = 4'h7;
   localparam logic [3:0] KEY_8 = 4'h8;
   localparam logic [3:0] KEY_9 = 4'h9;
   localparam logic [3:0] KEY_A = 4'hA;
   localparam logic [3:0] KEY_B = 4'hB;
   localparam logic [3:0] KEY_C = 4'hC;
   localparam logic [3:0] KEY_D = 4'hD;
   localparam logic [3:0] KEY_E = 4'hE;
   localparam logic [3:0] KEY_F = 4'hF;

   localparam int KEYPAD_FRAME_COLS = 4;

   typedef logic [3:0] key_code_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] row;
   } row_hit_t;

   // Scans from row 3 down so the lowest active row is the one left standing.
   function automatic row_hit_t first_row(input logic [3:0] rows_n);
      row_hit_t h;
      h = '0;
      for (int r = 3; r >= 0; r--)
         if (!rows_n[r]) begin
            h.valid = 1'b1;
            h.row   = 2'(r);
         end
      return h;
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: debounced key interface between the keypad scanner and the note decoder.
//   key         : debounced key code, holds its last value after release
//   pressed     : high while a debounced key is held
//   press_pulse : one-cycle strobe on each accepted press
//   master = producer (keypad_scan), slave = consumer (note decoder)
interface keypad_scan_if;
   import keypad_scan_pkg::*;

   key_code_t key;
   logic      pressed;
   logic      press_pulse;

   modport master(output key, pressed, press_pulse);
   modport slave (input  key, pressed, press_pulse);

endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level press/release confirmation for the keypad scanner.
//   clk, rst_n  : clock, synchronous active-low reset
//   frame_end   : one-cycle strobe at the end of each full scan frame
//   cand_valid  : a key was seen in the frame that is ending
//   cand_code   : highest-priority key code seen in that frame
//   key         : accepted key code, unchanged while pressed
//   pressed     : high while the accepted key is held
//   press_pulse : one-cycle strobe when a press is accepted
module keypad_debounce
   import keypad_scan_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      frame_end,
   input  logic      cand_valid,
   input  key_code_t cand_code,
   output key_code_t key,
   output logic      pressed,
   output logic      press_pulse
);

   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

   localparam logic [1:0] IDLE            = 2'd0;
   localparam logic [1:0] CONFIRM_PRESS   = 2'd1;
   localparam logic [1:0] HELD            = 2'd2;
   localparam logic [1:0] CONFIRM_RELEASE = 2'd3;

   // cnt already counts the current frame's predecessors, so cnt==LAST means
   // this frame is the DEBOUNCE_FRAMES-th one.
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_FRAMES - 1);
   localparam bit SINGLE = (DEBOUNCE_FRAMES == 1);

   logic [1:0]    state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   key_code_t     code, code_nx;
   logic          same, accept, drop;

   assign same = cand_valid && cand_code == code;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         code        <= '0;
         key         <= '0;
         pressed     <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         code        <= code_nx;
         press_pulse <= accept;
         if (accept) begin
            key     <= code_nx;
            pressed <= 1'b1;
         end else if (drop) begin
            pressed <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      code_nx  = code;
      if (frame_end)
         case (state)
            IDLE:
               if (cand_valid) begin
                  code_nx  = cand_code;
                  cnt_nx   = CW'(1);
                  state_nx = SINGLE ? HELD : CONFIRM_PRESS;
               end
            CONFIRM_PRESS:
               if (same) begin
                  cnt_nx = cnt + 1'b1;
                  if (cnt == LAST) state_nx = HELD;
               end else if (cand_valid) begin
                  code_nx = cand_code;
                  cnt_nx  = CW'(1);
               end else begin
                  state_nx = IDLE;
               end
            HELD:
               if (!same) begin
                  cnt_nx   = CW'(1);
                  state_nx = SINGLE ? IDLE : CONFIRM_RELEASE;
               end
            default:
               if (same) begin
                  state_nx = HELD;
               end else begin
                  cnt_nx = cnt + 1'b1;
                  if (cnt == LAST) state_nx = IDLE;
               end
         endcase
   end

   // Re-entering HELD from CONFIRM_RELEASE is not a new press; only entries
   // from the press side count.
   always_comb begin
      accept = state_nx == HELD && (state == IDLE || state == CONFIRM_PRESS);
      drop   = state_nx == IDLE && (state == HELD || state == CONFIRM_RELEASE);
   end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounced key output.
//   clk, rst_n : clock, synchronous active-low reset
//   row_n      : keypad rows, active low, asynchronous to clk
//   col_n      : column drive, one-hot low, registered
//   kif        : key / pressed / press_pulse producer port
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [3:0]          row_n,
   output logic [3:0]          col_n,
   keypad_scan_if.master       kif
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [1:0] LAST_COL = 2'(KEYPAD_FRAME_COLS - 1);

   logic [DW-1:0] div;
   logic [1:0]    col_idx;
   logic [3:0]    row_meta, row_sync;
   logic          tick, frame_end;
   logic          acc_valid;
   key_code_t     acc_code;
   row_hit_t      hit;
   logic          cand_valid;
   key_code_t     cand_code;

   assign tick      = div == DW'(SCAN_DIV - 1);
   assign frame_end = tick && col_idx == LAST_COL;
   assign hit       = first_row(row_sync);

   // Earlier columns win, so the column sampled on this tick only counts when
   // nothing has been accumulated yet this frame.
   assign cand_valid = acc_valid || hit.valid;
   assign cand_code  = acc_valid ? acc_code : {hit.row, col_idx};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div       <= '0;
         col_idx   <= '0;
         col_n     <= 4'b1110;
         row_meta  <= 4'hF;
         row_sync  <= 4'hF;
         acc_valid <= 1'b0;
         acc_code  <= '0;
      end else begin
         row_meta <= row_n;
         row_sync <= row_meta;
         div      <= tick ? '0 : div + 1'b1;
         if (tick) begin
            col_idx   <= col_idx + 2'd1;
            col_n     <= ~(4'b0001 << (col_idx + 2'd1));
            acc_valid <= cand_valid && !frame_end;
            acc_code  <= cand_code;
         end
      end
   end

   keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_end   (frame_end),
      .cand_valid  (cand_valid),
      .cand_code   (cand_code),
      .key         (kif.key),
      .pressed     (kif.pressed),
      .press_pulse (kif.press_pulse)
   );

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: scoreboard bench for keypad_scan with a frame-level keypad reference model.
module tb_keypad_scan;
   import keypad_scan_pkg::*;

   localparam int SD = 4;
   localparam int DF = 3;
   localparam int FR = 4 * SD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_n, col_n;
   logic [15:0] mask = '0;

   keypad_scan_if kif();

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .row_n (row_n),
      .col_n (col_n),
      .kif   (kif)
   );

   always #5 clk = ~clk;

   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (mask[r * 4 + c] && !col_n[c]) row_n[r] = 1'b0;
   end

   typedef struct {
      bit         rel;
      logic [3:0] key;
      int         k;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;
   int  k = 0;

   int         frame_no = 0;
   int         held = -1;
   int         run_key = -1;
   int         run_len = 0;
   int         miss = 0;
   logic [3:0] last_key = 4'h0;

   always @(posedge clk) k <= rst_n ? k + 1 : 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at k=%0d", nm, act, exp, k);
      end
   endtask

   function automatic int cand_of(input logic [15:0] m);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (m[r * 4 + c]) return r * 4 + c;
      return -1;
   endfunction

   task automatic model_frame(input logic [15:0] m);
      int  cd;
      ev_t e;
      cd = cand_of(m);
      frame_no++;
      if (held < 0) begin
         if (cd >= 0 && cd == run_key) run_len++;
         else begin
            run_key = cd;
            run_len = cd >= 0 ? 1 : 0;
         end
         if (run_len == DF) begin
            held = cd;
            last_key = 4'(cd);
            miss = 0;
            e.rel = 1'b0; e.key = 4'(cd); e.k = FR * frame_no;
            q.push_back(e);
         end
      end else begin
         miss = (cd == held) ? 0 : miss + 1;
         if (miss == DF) begin
            e.rel = 1'b1; e.key = 4'(held); e.k = FR * frame_no;
            q.push_back(e);
            held = -1;
            run_key = -1;
            run_len = 0;
         end
      end
   endtask

   task automatic frame(input logic [15:0] m);
      mask = m;
      model_frame(m);
      repeat (FR) @(negedge clk);
   endtask

   task automatic frames(input logic [15:0] m, input int n);
      for (int i = 0; i < n; i++) frame(m);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      mask = '0;
      repeat (n) @(negedge clk);
      chk("rst_col_n", col_n, 4'b1110);
      chk("rst_key", kif.key, 4'h0);
      chk("rst_pressed", kif.pressed, 1'b0);
      chk("rst_pulse", kif.press_pulse, 1'b0);
      q.delete();
      frame_no = 0; held = -1; run_key = -1; run_len = 0; miss = 0; last_key = 4'h0;
      rst_n = 1'b1;
   endtask

   logic       prev_pressed = 1'b0;
   logic [3:0] prev_key = 4'h0;

   always @(negedge clk) begin
      ev_t        e;
      logic [3:0] ec;
      if (rst_n) begin
         ec = ~(4'b0001 << ((k / SD) % 4));
         chk("col_n", col_n, ec);
         if (kif.press_pulse) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_press key %0h expected none at k=%0d", kif.key, k);
            end else begin
               e = q.pop_front();
               chk("press_kind", e.rel, 1'b0);
               chk("press_key", kif.key, e.key);
               chk("press_time", k, e.k);
               chk("press_level", kif.pressed, 1'b1);
            end
         end
         if (prev_pressed && !kif.pressed) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_release key %0h expected none at k=%0d", kif.key, k);
            end else begin
               e = q.pop_front();
               chk("release_kind", e.rel, 1'b1);
               chk("release_key", kif.key, e.key);
               chk("release_time", k, e.k);
            end
         end
         if (prev_pressed && kif.pressed) chk("key_stable", kif.key, prev_key);
      end
      prev_pressed = kif.pressed;
      prev_key = kif.key;
   end

   initial begin
      logic [15:0] m;
      do_reset(2);
      frames(16'h0000, 10);
      chk("idle_pressed", kif.pressed, 1'b0);

      frames(16'h0040, 6);
      chk("hold6_pressed", kif.pressed, 1'b1);
      chk("hold6_key", kif.key, 4'h6);

      frames(16'h0000, 2);
      frame(16'h0040);
      chk("reappear_pressed", kif.pressed, 1'b1);
      frames(16'h0000, 3);
      chk("release_pressed", kif.pressed, 1'b0);
      chk("release_key_kept", kif.key, 4'h6);
      frames(16'h0000, 2);

      frame(16'h0040); frame(16'h0000); frame(16'h0040); frame(16'h0000);
      chk("bounce_pressed", kif.pressed, 1'b0);
      frames(16'h0040, 3);
      chk("bounce_accept", kif.pressed, 1'b1);
      chk("bounce_key", kif.key, 4'h6);
      frames(16'h0000, 3);

      frames(16'h0420, 4);
      chk("multi_pressed", kif.pressed, 1'b1);
      chk("multi_key", kif.key, 4'h5);
      frames(16'h0000, 3);

      frames(16'h0200, 2);
      do_reset(3);
      frames(16'h0000, 4);
      chk("after_rst_pressed", kif.pressed, 1'b0);

      m = '0;
      for (int i = 0; i < 90; i++) begin
         if ($urandom_range(0, 9) >= 6) begin
            case ($urandom_range(0, 2))
               0: m = '0;
               1: m = 16'h0001 << $urandom_range(0, 15);
               default: m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            endcase
         end
         frame(m);
      end
      frames(16'h0000, DF + 1);
      @(negedge clk);

      chk("pending_events", q.size(), 0);
      chk("final_pressed", kif.pressed, held >= 0);
      chk("final_key", kif.key, last_key);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans the 4x4 matrix keypad by driving one column low at a time and sampling the four row lines.
- Debounces the result and produces the `key`/`pressed` pair consumed by the note decoder.
- This is the producer side of the key interface: `key` carries a KEY_0..KEY_F code, and `pressed` is asserted only while one key is held stably.
- Sits between the keypad pins and the note/pitch logic.

Parameters:
- SCAN_DIV, 50000: clk cycles per column slot. Legal range is >= 4, covering the 2-cycle row sync plus settle time.
- DEBOUNCE_FRAMES, 5: number of consecutive identical full scan frames needed to accept a press or a release. Legal range is >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- row_n  in  4  keypad row lines, active low, asynchronous to clk.
- col_n  out  4  keypad column drive, one-hot low.
- key  out  4  debounced key code = {row_idx, col_idx}, so KEY_n = 4'hn.
- pressed  out  1  high while a debounced key is held.
- press_pulse  out  1  one-cycle strobe on each accepted press.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - col_n=4'b1110, key=4'h0, pressed=0, press_pulse=0.
  - Divider, column index and frame counter to 0.
  - Row synchronizer to 4'b1111.
  - FSM to IDLE.
- Reset mid-operation aborts any confirm in progress. No output glitches other than the reset values.
- Row input: 2-FF synchronizer on row_n. All decisions use the synced value.
- Divider: counts 0..SCAN_DIV-1. A tick occurs when it reaches SCAN_DIV-1, after which it wraps to 0.
- Column index: 2-bit col_idx advances on each tick, 3 wraps to 0. col_n = ~(4'b0001 << col_idx), registered.
- Row sampling: on a tick, the synced rows are sampled for the current col_idx before the column advances.
- Per-frame candidate: the first active (row bit low) key found in scan order col 0..3, and within a column row 0..3.
  - This gives a candidate code {row, col} plus a valid flag.
  - With multiple keys, the lowest col wins, then the lowest row. No ghost rejection.
- Frame end: the tick with col_idx==3. The candidate then resets for the next frame.
- FSM, evaluated only at frame end; cnt is the frame counter:
  - IDLE: valid candidate → latch cand_code; cnt=1; go to CONFIRM_PRESS. If DEBOUNCE_FRAMES==1, go directly to HELD and perform the accept actions.
  - CONFIRM_PRESS:
    - Same code → cnt++. When cnt reaches DEBOUNCE_FRAMES → HELD, with the accept actions below.
    - Different valid code → restart with the new code, cnt=1.
    - No candidate → IDLE.
  - Accept actions: key<=code, pressed<=1, press_pulse high for exactly 1 cycle.
  - HELD:
    - Candidate equals the held code → stay in HELD.
    - Otherwise (none or a different code) → CONFIRM_RELEASE with cnt=1, or go directly to IDLE with pressed<=0 if DEBOUNCE_FRAMES==1.
  - CONFIRM_RELEASE:
    - Held code seen again → HELD, with no new press_pulse.
    - Otherwise → cnt++. When cnt reaches DEBOUNCE_FRAMES → IDLE, pressed<=0.
- key retains its last value after release. key never changes while pressed=1.
- Rolling to a new key without release: the first key must release (DEBOUNCE_FRAMES frames) before the new key is confirmed from IDLE.
- Latency: press is accepted at the frame end of the DEBOUNCE_FRAMES-th consecutive frame containing the key. Outputs update 1 cycle after that tick edge (registered).
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_FRAMES+1). Neither counter may overflow.

Decomposition:
- The shared param include already holds KEY_0..KEY_F. Add KEYPAD_FRAME_COLS=4 there.
- FSM state encodings are localparams inside the debounce sub-module.
- One sub-module: keypad_debounce. Inputs are frame_end, cand_valid, cand_code; outputs are key, pressed, press_pulse.
- keypad_scan holds the divider, column drive, synchronizer and candidate logic.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 clk; a keypad model pulls row_n[r] low while col_n[c]=0 for a pressed key):
- Reset: rst_n low 2 cycles → col_n=1110, key=0, pressed=0, press_pulse=0. Hold rst_n low mid-CONFIRM_PRESS → pressed stays 0 and the FSM restarts from IDLE.
- Rotation, no key: col_n sequence 1110→1101→1011→0111→1110, changing every 4 cycles. pressed stays 0 for 10 frames.
- Clean press of key 6 (row1, col2) held:
  - pressed rises after the 3rd frame end with key=4'h6.
  - press_pulse is high exactly one cycle.
  - No further pulses while held.
- Bounce: key 6 present in alternate frames for 4 frames → pressed stays 0. Then stable for 3 frames → press accepted, key=6.
- Simultaneous keys 5 (row1,col1) and A (row2,col2) → key=4'h5.
- Release of held key 6:
  - Absent 2 frames, then present again → pressed stays 1, no pulse.
  - Absent 3 frames → pressed falls; key stays 4'h6.
